// File: rtl/processor_dispatch_pkg.sv
// Shared opcode, width and state definitions for processor_dispatch.
// Build option: DISPATCH_PERF_CNT_EN adds the performance counters in the top.
package dispatch_pkg;

   localparam int unsigned INSTR_W  = 8;
   localparam int unsigned MEMSEL_W = 4;

   localparam logic [INSTR_W-1:0] OP_NOP    = 8'd0;
   localparam logic [INSTR_W-1:0] OP_DDR_LD = 8'd3;
   localparam logic [INSTR_W-1:0] OP_DDR_ST = 8'd4;
   localparam logic [INSTR_W-1:0] OP_SYNC   = 8'd254;
   localparam logic [INSTR_W-1:0] OP_HALT   = 8'd255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC_WAIT,
      ST_HALT_WAIT,
      ST_HALTED
   } state_t;

   typedef enum logic [2:0] {
      CL_NOP,
      CL_DDR,
      CL_SYNC,
      CL_HALT,
      CL_COMP
   } op_class_t;

   function automatic op_class_t classify(input logic [INSTR_W-1:0] op);
      op_class_t cl;
      case (op)
         OP_NOP:               cl = CL_NOP;
         OP_DDR_LD, OP_DDR_ST: cl = CL_DDR;
         OP_SYNC:              cl = CL_SYNC;
         OP_HALT:              cl = CL_HALT;
         default:              cl = CL_COMP;
      endcase
      return cl;
   endfunction

endpackage

// File: rtl/processor_dispatch_if.sv
// Instruction word handshake between the fetch sequencer (master) and the dispatcher (slave).
interface processor_dispatch_if;
   import dispatch_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [INSTR_W-1:0]  in_instruction;
   logic [7:0]          in_operand1;
   logic [7:0]          in_operand2;
   logic [2:0]          in_processor_sel;
   logic [MEMSEL_W-1:0] in_memory_sel;
   logic                in_modulus_sel;

   modport master (
      output in_valid, in_instruction, in_operand1, in_operand2,
             in_processor_sel, in_memory_sel, in_modulus_sel,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_instruction, in_operand1, in_operand2,
             in_processor_sel, in_memory_sel, in_modulus_sel,
      output in_ready
   );

endinterface

// File: rtl/processor_dispatch_busy_scoreboard.sv
// Per-target busy bits: set on issue, cleared by the target's done pulse.
module busy_scoreboard #(
   parameter int unsigned WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] set,
   input  logic [WIDTH-1:0] clr,
   output logic [WIDTH-1:0] busy,
   output logic             illegal_done
);

   always_ff @(posedge clk) begin
      if (!rst_n) busy <= '0;
      else        busy <= (busy & ~clr) | set;
   end

   // A done on a target that was never issued to is a protocol error.
   always_comb illegal_done = |(clr & ~busy);

endmodule

// File: rtl/processor_dispatch.sv
// Routes instruction words to compute processors / DDR engine with a busy scoreboard,
// SYNC barrier and HALT drain. Build option: DISPATCH_PERF_CNT_EN adds perf counters.
module processor_dispatch
   import dispatch_pkg::*;
#(
   parameter int unsigned NUM_PROC = 6
) (
   input  logic                clk,
   input  logic                start_eth,
   processor_dispatch_if.slave in_bus,
   output logic [NUM_PROC-1:0] proc_start,
   output logic                ddr_start,
   output logic [INSTR_W-1:0]  out_instruction,
   output logic [7:0]          out_operand1,
   output logic [7:0]          out_operand2,
   output logic [MEMSEL_W-1:0] out_memory_sel,
   output logic                out_modulus_sel,
   input  logic [NUM_PROC-1:0] proc_done,
   input  logic                ddr_done,
   output logic [NUM_PROC:0]   busy,
   output logic                halted,
   output logic                err
`ifdef DISPATCH_PERF_CNT_EN
   ,
   output logic [31:0]         perf_issue_cnt,
   output logic [31:0]         perf_stall_cnt
`endif
);

   state_t              state_q, state_d;
   op_class_t           op_class;
   logic                ready;
   logic                accept;
   logic                acc_proc;
   logic                acc_ddr;
   logic                bad_sel;
   logic                sel_legal;
   logic                sel_busy;
   logic [NUM_PROC-1:0] proc_set;
   logic [NUM_PROC:0]   sb_set;
   logic                illegal_done;

   // Out-of-range selects decode to all-zero, which doubles as the legality test.
   always_comb begin
      proc_set = '0;
      for (int unsigned i = 0; i < NUM_PROC; i++)
         proc_set[i] = (32'(in_bus.in_processor_sel) == i);
   end

   always_comb begin
      op_class  = classify(in_bus.in_instruction);
      sel_legal = |proc_set;
      sel_busy  = |(busy[NUM_PROC-1:0] & proc_set);
   end

   always_comb begin
      state_d  = state_q;
      ready    = 1'b0;
      accept   = 1'b0;
      acc_proc = 1'b0;
      acc_ddr  = 1'b0;
      bad_sel  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            unique case (op_class)
               CL_NOP, CL_SYNC, CL_HALT: ready = 1'b1;
               CL_DDR:                   ready = !busy[NUM_PROC];
               CL_COMP:                  ready = !sel_legal || !sel_busy;
               default:                  ready = 1'b0;
            endcase
            accept = in_bus.in_valid && ready && start_eth;
            if (accept) begin
               unique case (op_class)
                  CL_SYNC: state_d  = ST_SYNC_WAIT;
                  CL_HALT: state_d  = ST_HALT_WAIT;
                  CL_DDR:  acc_ddr  = 1'b1;
                  CL_COMP: begin
                     acc_proc = sel_legal;
                     bad_sel  = !sel_legal;
                  end
                  default: ;
               endcase
            end
         end
         ST_SYNC_WAIT: if (busy == '0) state_d = ST_IDLE;
         ST_HALT_WAIT: if (busy == '0) state_d = ST_HALTED;
         ST_HALTED:    ;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_bus.in_ready = ready && start_eth;
      halted          = (state_q == ST_HALTED);
      sb_set          = {acc_ddr, acc_proc ? proc_set : '0};
   end

   busy_scoreboard #(
      .WIDTH (NUM_PROC + 1)
   ) u_scoreboard (
      .clk          (clk),
      .rst_n        (start_eth),
      .set          (sb_set),
      .clr          ({ddr_done, proc_done}),
      .busy         (busy),
      .illegal_done (illegal_done)
   );

   always_ff @(posedge clk) begin
      if (!start_eth) begin
         state_q         <= ST_IDLE;
         proc_start      <= '0;
         ddr_start       <= 1'b0;
         out_instruction <= '0;
         out_operand1    <= '0;
         out_operand2    <= '0;
         out_memory_sel  <= '0;
         out_modulus_sel <= 1'b0;
         err             <= 1'b0;
      end else begin
         state_q    <= state_d;
         proc_start <= acc_proc ? proc_set : '0;
         ddr_start  <= acc_ddr;
         if (acc_proc || acc_ddr) begin
            out_instruction <= in_bus.in_instruction;
            out_operand1    <= in_bus.in_operand1;
            out_operand2    <= in_bus.in_operand2;
            out_memory_sel  <= in_bus.in_memory_sel;
            out_modulus_sel <= in_bus.in_modulus_sel;
         end
         if (bad_sel || illegal_done) err <= 1'b1;
      end
   end

`ifdef DISPATCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!start_eth) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (accept && op_class != CL_NOP && perf_issue_cnt != '1)
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         if (state_q == ST_IDLE && in_bus.in_valid && !ready && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_processor_dispatch.sv
// Directed self-checking bench for processor_dispatch (NUM_PROC=6).
module tb_processor_dispatch;
   logic       clk;
   logic       start_eth;
   logic [5:0] proc_start;
   logic       ddr_start;
   logic [7:0] out_instruction, out_operand1, out_operand2;
   logic [3:0] out_memory_sel;
   logic       out_modulus_sel;
   logic [5:0] proc_done;
   logic       ddr_done;
   logic [6:0] busy;
   logic       halted, err;
`ifdef DISPATCH_PERF_CNT_EN
   logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif
   int n_checks = 0;
   int n_fail   = 0;

   processor_dispatch_if bus ();

   processor_dispatch #(.NUM_PROC(6)) dut (
      .clk             (clk),
      .start_eth       (start_eth),
      .in_bus          (bus),
      .proc_start      (proc_start),
      .ddr_start       (ddr_start),
      .out_instruction (out_instruction),
      .out_operand1    (out_operand1),
      .out_operand2    (out_operand2),
      .out_memory_sel  (out_memory_sel),
      .out_modulus_sel (out_modulus_sel),
      .proc_done       (proc_done),
      .ddr_done        (ddr_done),
      .busy            (busy),
      .halted          (halted),
      .err             (err)
`ifdef DISPATCH_PERF_CNT_EN
      ,
      .perf_issue_cnt  (perf_issue_cnt),
      .perf_stall_cnt  (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [7:0] op, input logic [2:0] sel);
      bus.in_valid         = 1'b1;
      bus.in_instruction   = op;
      bus.in_processor_sel = sel;
      bus.in_operand1      = op ^ 8'h5A;
      bus.in_operand2      = ~op;
      bus.in_memory_sel    = op[3:0];
      bus.in_modulus_sel   = op[0];
   endtask

   task automatic test_reset();
      start_eth = 1'b0;
      drive(8'd7, 3'd2);
      proc_done = '1;
      ddr_done  = 1'b1;
      tick(); tick(); #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
      n_checks++; if (proc_start !== 6'b0) begin n_fail++; $display("FAIL reset proc_start: got %b want 000000", proc_start); end
      n_checks++; if (ddr_start !== 1'b0) begin n_fail++; $display("FAIL reset ddr_start: got %b want 0", ddr_start); end
      n_checks++; if (busy !== 7'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0000000", busy); end
      n_checks++; if (halted !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset halted/err: got %b/%b want 0/0", halted, err); end
      n_checks++; if (out_instruction !== 8'd0) begin n_fail++; $display("FAIL reset out_instruction: got %0d want 0", out_instruction); end
      proc_done    = '0;
      ddr_done     = 1'b0;
      bus.in_valid = 1'b0;
      start_eth    = 1'b1;
      tick();
   endtask

   task automatic test_single_issue();
      drive(8'd7, 3'd2); #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single ready: got %b want 1", bus.in_ready); end
      tick();
      n_checks++; if (proc_start !== 6'b000100) begin n_fail++; $display("FAIL single start: got %b want 000100", proc_start); end
      n_checks++; if (busy !== 7'b0000100) begin n_fail++; $display("FAIL single busy: got %b want 0000100", busy); end
      n_checks++; if (out_instruction !== 8'd7 || out_operand1 !== 8'h5D || out_operand2 !== 8'hF8) begin n_fail++; $display("FAIL single fields: got %h %h %h want 07 5d f8", out_instruction, out_operand1, out_operand2); end
      n_checks++; if (out_memory_sel !== 4'd7 || out_modulus_sel !== 1'b1) begin n_fail++; $display("FAIL single memsel/mod: got %h/%b want 7/1", out_memory_sel, out_modulus_sel); end
      drive(8'd8, 3'd2); #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall ready: got %b want 0", bus.in_ready); end
      tick();
      n_checks++; if (proc_start !== 6'b0) begin n_fail++; $display("FAIL single pulse width: got %b want 000000", proc_start); end
      n_checks++; if (out_instruction !== 8'd7) begin n_fail++; $display("FAIL fields hold: got %0d want 7", out_instruction); end
      proc_done = 6'b000100; #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL done bypass ready: got %b want 0", bus.in_ready); end
      tick();
      proc_done = '0; #1;
      n_checks++; if (busy !== 7'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL after done busy/ready: got %b/%b want 0000000/1", busy, bus.in_ready); end
      n_checks++; if (proc_start !== 6'b0) begin n_fail++; $display("FAIL stalled early issue: got %b want 000000", proc_start); end
      tick();
      n_checks++; if (proc_start !== 6'b000100 || out_instruction !== 8'd8) begin n_fail++; $display("FAIL stalled issue: got %b/%0d want 000100/8", proc_start, out_instruction); end
      bus.in_valid = 1'b0;
      proc_done    = 6'b000100;
      tick();
      proc_done = '0;
   endtask

   task automatic test_back_to_back();
      drive(8'd10, 3'd0); tick();
      n_checks++; if (proc_start !== 6'b000001) begin n_fail++; $display("FAIL b2b start0: got %b want 000001", proc_start); end
      drive(8'd11, 3'd1); tick();
      n_checks++; if (proc_start !== 6'b000010) begin n_fail++; $display("FAIL b2b start1: got %b want 000010", proc_start); end
      drive(8'd12, 3'd2); tick();
      n_checks++; if (proc_start !== 6'b000100 || out_instruction !== 8'd12) begin n_fail++; $display("FAIL b2b start2: got %b/%0d want 000100/12", proc_start, out_instruction); end
      n_checks++; if (busy !== 7'b0000111) begin n_fail++; $display("FAIL b2b busy: got %b want 0000111", busy); end
      bus.in_valid = 1'b0; tick();
      n_checks++; if (proc_start !== 6'b0) begin n_fail++; $display("FAIL b2b idle start: got %b want 000000", proc_start); end
      proc_done = 6'b000111; tick();
      proc_done = '0;
      n_checks++; if (busy !== 7'b0 || err !== 1'b0) begin n_fail++; $display("FAIL b2b clear busy/err: got %b/%b want 0000000/0", busy, err); end
   endtask

   task automatic test_ddr();
      drive(8'd4, 3'd0); tick();
      n_checks++; if (ddr_start !== 1'b1 || busy !== 7'b1000000 || proc_start !== 6'b0) begin n_fail++; $display("FAIL ddr issue: got %b/%b/%b want 1/1000000/000000", ddr_start, busy, proc_start); end
      drive(8'd3, 3'd0); #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ddr stall ready: got %b want 0", bus.in_ready); end
      tick();
      n_checks++; if (ddr_start !== 1'b0) begin n_fail++; $display("FAIL ddr pulse width: got %b want 0", ddr_start); end
      ddr_done = 1'b1; tick();
      ddr_done = 1'b0; #1;
      n_checks++; if (busy !== 7'b0 || bus.in_ready !== 1'b1 || ddr_start !== 1'b0) begin n_fail++; $display("FAIL ddr after done: got %b/%b/%b want 0000000/1/0", busy, bus.in_ready, ddr_start); end
      tick();
      n_checks++; if (ddr_start !== 1'b1 || out_instruction !== 8'd3) begin n_fail++; $display("FAIL ddr second issue: got %b/%0d want 1/3", ddr_start, out_instruction); end
      bus.in_valid = 1'b0; tick();
      n_checks++; if (ddr_start !== 1'b0) begin n_fail++; $display("FAIL ddr second pulse width: got %b want 0", ddr_start); end
      ddr_done = 1'b1; tick();
      ddr_done = 1'b0;
   endtask

   task automatic test_sync();
      drive(8'd254, 3'd0); #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL empty sync ready: got %b want 1", bus.in_ready); end
      tick();
      drive(8'd13, 3'd5); #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL empty sync wait: got %b want 0", bus.in_ready); end
      tick();
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL empty sync return: got %b want 1", bus.in_ready); end
      tick();
      n_checks++; if (proc_start !== 6'b100000) begin n_fail++; $display("FAIL after empty sync issue: got %b want 100000", proc_start); end
      bus.in_valid = 1'b0; proc_done = 6'b100000; tick(); proc_done = '0;

      drive(8'd20, 3'd0); tick();
      drive(8'd21, 3'd3); tick();
      drive(8'd254, 3'd0); #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL sync accept: got %b want 1", bus.in_ready); end
      tick();
      drive(8'd9, 3'd4); tick(); tick();
      n_checks++; if (bus.in_ready !== 1'b0 || proc_start !== 6'b0) begin n_fail++; $display("FAIL sync hold: got %b/%b want 0/000000", bus.in_ready, proc_start); end
      proc_done = 6'b000001; tick(); proc_done = '0;
      n_checks++; if (busy !== 7'b0001000 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL sync one done: got %b/%b want 0001000/0", busy, bus.in_ready); end
      proc_done = 6'b001000; tick(); proc_done = '0; #1;
      n_checks++; if (busy !== 7'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL sync drained: got %b/%b want 0000000/0", busy, bus.in_ready); end
      tick();
      n_checks++; if (bus.in_ready !== 1'b1 || proc_start !== 6'b0) begin n_fail++; $display("FAIL sync release: got %b/%b want 1/000000", bus.in_ready, proc_start); end
      tick();
      n_checks++; if (proc_start !== 6'b010000 || out_instruction !== 8'd9) begin n_fail++; $display("FAIL post-sync issue: got %b/%0d want 010000/9", proc_start, out_instruction); end
      bus.in_valid = 1'b0; proc_done = 6'b010000; tick(); proc_done = '0;
   endtask

   task automatic test_err();
      drive(8'd7, 3'd7); #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bad sel ready: got %b want 1", bus.in_ready); end
      tick();
      n_checks++; if (err !== 1'b1 || proc_start !== 6'b0 || busy !== 7'b0) begin n_fail++; $display("FAIL bad sel: got err %b start %b busy %b want 1/000000/0000000", err, proc_start, busy); end
      bus.in_valid = 1'b0; tick(); tick();
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err sticky: got %b want 1", err); end
      start_eth = 1'b0; tick(); start_eth = 1'b1;
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err reset: got %b want 0", err); end
      proc_done = 6'b010000; tick(); proc_done = '0;
      n_checks++; if (err !== 1'b1 || busy !== 7'b0) begin n_fail++; $display("FAIL stray done: got err %b busy %b want 1/0000000", err, busy); end
   endtask

   task automatic test_halt();
      start_eth = 1'b0; tick(); start_eth = 1'b1; tick();
      drive(8'd20, 3'd1); tick();
      n_checks++; if (busy !== 7'b0000010) begin n_fail++; $display("FAIL halt pre busy: got %b want 0000010", busy); end
      drive(8'd255, 3'd0); #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL halt accept: got %b want 1", bus.in_ready); end
      tick();
      drive(8'd7, 3'd0); #1;
      n_checks++; if (bus.in_ready !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL halt wait: got ready %b halted %b want 0/0", bus.in_ready, halted); end
      tick(); tick();
      n_checks++; if (halted !== 1'b0 || proc_start !== 6'b0) begin n_fail++; $display("FAIL halt drain: got %b/%b want 0/000000", halted, proc_start); end
      proc_done = 6'b000010; tick(); proc_done = '0;
      n_checks++; if (busy !== 7'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL halt done edge: got %b/%b want 0000000/0", busy, halted); end
      tick();
      n_checks++; if (halted !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL halted: got %b ready %b want 1/0", halted, bus.in_ready); end
      tick(); tick(); tick();
      n_checks++; if (halted !== 1'b1 || bus.in_ready !== 1'b0 || proc_start !== 6'b0) begin n_fail++; $display("FAIL halted hold: got %b/%b/%b want 1/0/000000", halted, bus.in_ready, proc_start); end
      ddr_done = 1'b1; tick(); ddr_done = 1'b0;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL halted stray ddr_done err: got %b want 1", err); end
      start_eth = 1'b0; tick(); start_eth = 1'b1; #1;
      n_checks++; if (halted !== 1'b0 || err !== 1'b0 || busy !== 7'b0) begin n_fail++; $display("FAIL halt reset: got halted %b err %b busy %b want 0/0/0000000", halted, err, busy); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL halt reset ready: got %b want 1", bus.in_ready); end
      tick();
      n_checks++; if (proc_start !== 6'b000001) begin n_fail++; $display("FAIL post-reset issue: got %b want 000001", proc_start); end
      bus.in_valid = 1'b0; proc_done = 6'b000001; tick(); proc_done = '0;
   endtask

   initial begin
      start_eth            = 1'b0;
      bus.in_valid         = 1'b0;
      bus.in_instruction   = '0;
      bus.in_operand1      = '0;
      bus.in_operand2      = '0;
      bus.in_processor_sel = '0;
      bus.in_memory_sel    = '0;
      bus.in_modulus_sel   = 1'b0;
      proc_done            = '0;
      ddr_done             = 1'b0;
      test_reset();
      test_single_issue();
      test_back_to_back();
      test_ddr();
      test_sync();
      test_err();
      test_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
